// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared constants, port ids and FSM encoding for the SRAM arbiter/controller.
package sram_arbiter_ctrl_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_grant.sv
// Combinational grant between fetch and data ports. SRAM_ARB_RR_EN selects
// round-robin (last-granted pointer flop); otherwise data wins over inst.
module sram_arbiter_ctrl_grant
  import sram_arbiter_ctrl_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take_i,
`endif
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic vld_o,
  output logic port_o
);

  assign vld_o = inst_req_i | data_req_i;

`ifdef SRAM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst)         last_q <= PORT_INST;
    else if (take_i) last_q <= port_o;
  end

  // On a collision hand the bus to whichever port did not have it last.
  always_comb begin
    if (inst_req_i && data_req_i) port_o = ~last_q;
    else                          port_o = data_req_i ? PORT_DATA : PORT_INST;
  end
`else
  assign port_o = data_req_i ? PORT_DATA : PORT_INST;
`endif

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Shares one async SRAM between fetch and data ports: arbitrate, sequence EN/OE/WE
// and the tri-state bus, return a one-cycle ack. SRAM_ARB_RR_EN enables round-robin.
module sram_arbiter_ctrl
  import sram_arbiter_ctrl_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ack,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ack,
  output logic              busy,
  output logic              Ram1EN,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic [ADDR_W-1:0] Ram1Address,
  inout  wire  [DATA_W-1:0] Ram1data
);

  localparam int CNT_W = $clog2(max2(READ_WAIT, WRITE_WAIT)) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_q, gnt_vld, gnt_port, gnt_take;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, inst_rdata_q, data_rdata_q;
  logic               drv_q, en_q, oe_q, we_q, inst_ack_q, data_ack_q;

  sram_arbiter_ctrl_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .take_i     (gnt_take),
`endif
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .vld_o      (gnt_vld),
    .port_o     (gnt_port)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_take = 1'b0;
    case (state_q)
      S_IDLE: if (gnt_vld) begin
        gnt_take = 1'b1;
        if (gnt_port == PORT_DATA && data_we) begin
          state_d = S_WR_SETUP;
        end else begin
          state_d = S_RD;
          cnt_d   = CNT_W'(READ_WAIT - 1);
        end
      end
      S_RD:       if (cnt_q == '0) state_d = S_DONE; else cnt_d = cnt_q - CNT_W'(1);
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = CNT_W'(WRITE_WAIT - 1);
      end
      S_WR_PULSE: if (cnt_q == '0) state_d = S_WR_HOLD; else cnt_d = cnt_q - CNT_W'(1);
      S_WR_HOLD:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they line up with state_q
  // and never glitch; OE and WE lows live in disjoint states.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q       <= PORT_INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      drv_q        <= 1'b0;
      en_q         <= 1'b1;
      oe_q         <= 1'b1;
      we_q         <= 1'b1;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (gnt_take) begin
        port_q  <= gnt_port;
        addr_q  <= (gnt_port == PORT_DATA) ? data_addr : inst_addr;
        wdata_q <= data_wdata;
      end
      en_q       <= (state_d == S_IDLE);
      oe_q       <= (state_d != S_RD);
      we_q       <= (state_d != S_WR_PULSE);
      drv_q      <= (state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
      inst_ack_q <= (state_d == S_DONE) && (port_q == PORT_INST);
      data_ack_q <= (state_d == S_DONE) && (port_q == PORT_DATA);
      if (state_q == S_RD && cnt_q == '0) begin
        if (port_q == PORT_DATA) data_rdata_q <= Ram1data;
        else                     inst_rdata_q <= Ram1data;
      end
    end
  end

  assign Ram1data    = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign Ram1EN      = en_q;
  assign Ram1OE      = oe_q;
  assign Ram1WE      = we_q;
  assign Ram1Address = addr_q;
  assign inst_ack    = inst_ack_q;
  assign data_ack    = data_ack_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Scoreboard bench for sram_arbiter_ctrl with a behavioural async SRAM on the bus.
module tb_sram_arbiter_ctrl;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          lat;
    bit          chk;
  } sb_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [19:0] inst_addr = '0, data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ack, data_ack, busy, Ram1EN, Ram1OE, Ram1WE;
  logic [19:0] Ram1Address;
  wire  [31:0] Ram1data;

  logic [31:0] mem [0:1048575];
  bit          pre = 1'b1, mon_en = 1'b0, busy_p = 1'b0;
  int          cyc = 0, grant_cyc = 0, n_vec = 0, n_err = 0;
  sb_t         sbq[$];
  sb_t         me;

  sram_arbiter_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack), .busy(busy),
    .Ram1EN(Ram1EN), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE),
    .Ram1Address(Ram1Address), .Ram1data(Ram1data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: drives the bus on EN&OE low, writes while EN&WE low.
  assign Ram1data = (!Ram1EN && !Ram1OE) ? mem[Ram1Address] : 32'bz;
  always @(posedge clk) begin
    if (pre) begin
      mem[20'h00004] <= 32'hA5A50004;
      mem[20'h00100] <= 32'h0BADF00D;
      mem[20'h00200] <= 32'h22222222;
      mem[20'h00020] <= 32'h11111111;
    end else if (!Ram1EN && !Ram1WE) begin
      mem[Ram1Address] <= Ram1data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pin rules every cycle, scoreboard pop on every ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !busy_p) grant_cyc = cyc - 1;
      busy_p = busy;
      chk("en_vs_idle", {31'd0, Ram1EN}, {31'd0, !busy});
      chk("oe_we_overlap", {31'd0, !Ram1OE && !Ram1WE}, 32'd0);
      if (!Ram1OE) chk("bus_clean_on_read", Ram1data, mem[Ram1Address]);
      if (inst_ack || data_ack) begin
        chk("single_ack", {31'd0, inst_ack && data_ack}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {31'd0, data_ack}, {31'd0, !data_ack});
        end else begin
          me = sbq.pop_front();
          chk("ack_port", {31'd0, data_ack}, {31'd0, me.port});
          chk("ack_latency", cyc - grant_cyc, me.lat);
          if (me.chk) chk("rdata", data_ack ? data_rdata : inst_rdata, me.data);
        end
      end
    end
  end

  task automatic wait_ack(input bit is_d, output int oe, output int wl, output int ac);
    bit seen;
    seen = 0; oe = 0; wl = 0; ac = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!Ram1OE) oe++;
      if (!Ram1WE) wl++;
      if (is_d ? data_ack : inst_ack) begin seen = 1; ac = cyc; end
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input bit is_d, input bit we, input logic [19:0] a,
                     input logic [31:0] wd, input logic [31:0] exp);
    sb_t e;
    int oe, wl, ac;
    e.port = is_d; e.data = exp; e.lat = we ? 5 : 3; e.chk = !we;
    sbq.push_back(e);
    if (is_d) begin data_we = we; data_addr = a; data_wdata = wd; data_req = 1; end
    else begin inst_addr = a; inst_req = 1; end
    wait_ack(is_d, oe, wl, ac);
    chk("oe_low_cycles", oe, we ? 0 : 2);
    chk("we_low_cycles", wl, we ? 2 : 0);
    chk("ack_seen", {31'd0, ac >= 0}, 32'd1);
    @(posedge clk); #1;
    if (is_d) data_req = 0; else inst_req = 0;
  endtask

  task automatic coll(input bit data_first, input logic [31:0] iexp,
                      input logic [19:0] da, input logic [31:0] dexp);
    sb_t ei, ed;
    int oe, wl, ac;
    ei.port = 0; ei.data = iexp; ei.lat = 3; ei.chk = 1;
    ed.port = 1; ed.data = dexp; ed.lat = 3; ed.chk = 1;
    if (data_first) begin sbq.push_back(ed); sbq.push_back(ei); end
    else begin sbq.push_back(ei); sbq.push_back(ed); end
    inst_addr = 20'h00004; data_addr = da; data_we = 0;
    inst_req = 1; data_req = 1;
    wait_ack(data_first, oe, wl, ac);
    chk("coll_first_oe", oe, 2);
    @(posedge clk); #1;
    if (data_first) data_req = 0; else inst_req = 0;
    wait_ack(!data_first, oe, wl, ac);
    chk("coll_second_we", wl, 0);
    @(posedge clk); #1;
    inst_req = 0; data_req = 0;
  endtask

  initial begin
    sb_t e;
    int a0, a1, a2, oe, wl;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    pre = 0;
    @(negedge clk);
    chk("rst_en", {31'd0, Ram1EN}, 32'd1);
    chk("rst_oe", {31'd0, Ram1OE}, 32'd1);
    chk("rst_we", {31'd0, Ram1WE}, 32'd1);
    chk("rst_addr", {12'd0, Ram1Address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, inst_ack, data_ack}, 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 0; mon_en = 1;

    // Write then read back, fetch alone.
    txn(1, 1, 20'h00010, 32'hDEADBEEF, 32'h0);
    txn(1, 0, 20'h00010, 32'h0, 32'hDEADBEEF);
    txn(0, 0, 20'h00004, 32'h0, 32'hA5A50004);

    // Collisions: data wins first; after a lone data grant round-robin flips.
    coll(1, 32'hA5A50004, 20'h00100, 32'h0BADF00D);
    txn(1, 0, 20'h00200, 32'h0, 32'h22222222);
`ifdef SRAM_ARB_RR_EN
    coll(0, 32'hA5A50004, 20'h00100, 32'h0BADF00D);
`else
    coll(1, 32'hA5A50004, 20'h00100, 32'h0BADF00D);
`endif

    // Fetch held high across three acks: one IDLE between each.
    e.port = 0; e.data = 32'hA5A50004; e.lat = 3; e.chk = 1;
    repeat (3) sbq.push_back(e);
    inst_addr = 20'h00004; inst_req = 1;
    wait_ack(0, oe, wl, a0);
    wait_ack(0, oe, wl, a1);
    wait_ack(0, oe, wl, a2);
    @(posedge clk); #1;
    inst_req = 0;
    chk("b2b_gap1", a1 - a0, 4);
    chk("b2b_gap2", a2 - a1, 4);
    chk("b2b_oe_last", oe + wl, 2);

    // Reset in the middle of the write pulse: abort, no ack.
    data_addr = 20'h00020; data_wdata = 32'hCAFEF00D; data_we = 1; data_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!Ram1WE) seen = 1;
    end
    chk("we_pulse_seen", {31'd0, seen}, 32'd1);
    rst = 1; data_req = 0;
    @(negedge clk);
    chk("abort_we", {31'd0, Ram1WE}, 32'd1);
    chk("abort_en", {31'd0, Ram1EN}, 32'd1);
    chk("abort_oe", {31'd0, Ram1OE}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", {12'd0, Ram1Address}, 32'd0);
    chk("abort_ack", {31'd0, data_ack}, 32'd0);
    chk("abort_rdata", data_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_word", mem[20'h00020], 32'hCAFEF00D);
    txn(1, 0, 20'h00020, 32'h0, 32'hCAFEF00D);

    // Top of the address space.
    txn(1, 1, 20'hFFFFF, 32'h12345678, 32'h0);
    txn(1, 0, 20'hFFFFF, 32'h0, 32'h12345678);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
